// File: rtl/horner_poly_pipeline_pkg.sv
// Shared Q-format constants and coefficient table for the Horner series pipeline.
package horner_poly_pipeline_pkg;

  // Default Q16.16 format used by the series datapath
  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 16;

  // Saturation limits at the default width
  localparam logic signed [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  // c_k = floor(2^frac / (k+1)), negated for odd k in the alternating form.
  // Returned wide; callers truncate to their data width.
  function automatic logic signed [63:0] coef(input int k, input int frac, input bit alt);
    logic signed [63:0] c;
    c = (64'sd1 <<< frac) / 64'(k + 1);
    if (alt && k[0]) c = -c;
    return c;
  endfunction

endpackage

// File: rtl/horner_poly_pipeline_mac_stage.sv
// One Horner step: acc_out = sat_or_wrap((a*x >>> FRAC) + COEF), with the
// per-sample overflow flag OR-ed forward. All registers load only on en_i.
module horner_mac_stage
  import horner_poly_pipeline_pkg::*;
#(
  parameter int                      WIDTH    = DEF_WIDTH,
  parameter int                      FRAC     = DEF_FRAC,
  parameter bit                      SATURATE = 1'b1,
  parameter logic signed [WIDTH-1:0] COEF     = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic                    ovf_i,
  output logic                    v_o,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] acc_o,
  output logic                    ovf_o
);

  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] prod_sh;
  logic        [2*WIDTH:0]   sum;
  logic                      ovf_here;
  logic signed [WIDTH-1:0]   acc_d;

  logic                      v_q;
  logic signed [WIDTH-1:0]   x_q;
  logic signed [WIDTH-1:0]   acc_q;
  logic                      ovf_q;

  // Full-width multiply, floor-shift, then add the coefficient one bit wider
  // so the sum itself can never wrap before the range check.
  always_comb begin
    prod     = a_i * x_i;
    prod_sh  = prod >>> FRAC;
    sum      = {prod_sh[2*WIDTH-1], prod_sh} + (2*WIDTH+1)'(COEF);
    // In range only when every bit from the top down to bit WIDTH-1 agrees.
    ovf_here = !((&sum[2*WIDTH:WIDTH-1]) || !(|sum[2*WIDTH:WIDTH-1]));
    acc_d    = sum[WIDTH-1:0];
    if (ovf_here && SATURATE) acc_d = sum[2*WIDTH] ? SMIN : SMAX;
  end

  // Stage registers advance together under the global enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= 1'b0;
      x_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      v_q   <= v_i;
      x_q   <= x_i;
      acc_q <= acc_d;
      ovf_q <= ovf_i | ovf_here;
    end
  end

  assign v_o   = v_q;
  assign x_o   = x_q;
  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/horner_poly_pipeline.sv
// Fully pipelined Horner evaluator, one multiply-add stage per degree, with a
// global stall, per-sample overflow tracking and delivered-overflow counters.
module horner_poly_pipeline
  import horner_poly_pipeline_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRAC     = DEF_FRAC,
  parameter int DEGREE   = 4,
  parameter int ALT_SIGN = 0,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] y_out,
  output logic                    ovf_out,
  output logic                    ovf_sticky,
  output logic [CNT_W-1:0]        ovf_count,
  input  logic                    clear
);

  // Leading coefficient seeds the accumulator chain at stage 0.
  localparam logic [WIDTH-1:0] C_LEAD = WIDTH'(coef(DEGREE, FRAC, ALT_SIGN != 0));

  // Index 0 is the pipeline input; index s is the output of stage s.
  logic [DEGREE:0]             v_s;
  logic [DEGREE:0]             ovf_s;
  logic [DEGREE:0][WIDTH-1:0]  x_s;
  logic [DEGREE:0][WIDTH-1:0]  acc_s;
  logic                        adv;

  logic                        sticky_q, sticky_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        unused_ok;

  // Whole pipe moves unless a valid result is waiting on downstream.
  assign adv      = !v_s[DEGREE] || out_ready;
  assign in_ready = adv;

  assign v_s[0]   = in_valid;
  assign x_s[0]   = x_in;
  assign acc_s[0] = C_LEAD;
  assign ovf_s[0] = 1'b0;

  for (genvar s = 1; s <= DEGREE; s++) begin : g_stage
    localparam logic [WIDTH-1:0] CK = WIDTH'(coef(DEGREE - s, FRAC, ALT_SIGN != 0));
    horner_mac_stage #(
      .WIDTH    (WIDTH),
      .FRAC     (FRAC),
      .SATURATE (SATURATE != 0),
      .COEF     (CK)
    ) u_mac (
      .clk   (clk),
      .reset (reset),
      .en_i  (adv),
      .v_i   (v_s[s-1]),
      .a_i   (acc_s[s-1]),
      .x_i   (x_s[s-1]),
      .ovf_i (ovf_s[s-1]),
      .v_o   (v_s[s]),
      .x_o   (x_s[s]),
      .acc_o (acc_s[s]),
      .ovf_o (ovf_s[s])
    );
  end

  // The argument is not needed past the last stage.
  assign unused_ok = ^x_s[DEGREE];

  assign out_valid = v_s[DEGREE];
  assign y_out     = acc_s[DEGREE];
  assign ovf_out   = ovf_s[DEGREE];

  // Count overflowed samples as they leave; clear beats a same-cycle increment.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clear) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (out_valid && out_ready && ovf_out) begin
      sticky_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Overflow bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ovf_sticky = sticky_q;
  assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_horner_poly_pipeline.sv
// Bench for horner_poly_pipeline: three configurations share one stimulus
// stream (saturating, alternating-sign, wrapping). An integer reference model
// plus a scoreboard checks every delivered sample; directed literals pin it.
module tb_horner_poly_pipeline;

  localparam int W = 32;
  localparam int F = 16;
  localparam int D = 4;

  logic clk, reset, in_valid, out_ready, clear;
  logic [W-1:0] x_in;

  logic [2:0]          in_rdy, o_vld, o_ovf, o_stk;
  logic [2:0][W-1:0]   o_y;
  logic [2:0][15:0]    o_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] xq[$];
  logic [W-1:0] vals [8] = '{32'h00008000, 32'hFFFF0000, 32'h00020000, 32'hFFFE8000,
                             32'h00001234, 32'h80000000, 32'h00030000, 32'hFFFFFFFF};

  horner_poly_pipeline #(.WIDTH(W), .FRAC(F), .DEGREE(D), .ALT_SIGN(0), .SATURATE(1), .CNT_W(16)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[0]), .x_in(x_in),
    .out_valid(o_vld[0]), .out_ready(out_ready), .y_out(o_y[0]), .ovf_out(o_ovf[0]),
    .ovf_sticky(o_stk[0]), .ovf_count(o_cnt[0]), .clear(clear));

  horner_poly_pipeline #(.WIDTH(W), .FRAC(F), .DEGREE(D), .ALT_SIGN(1), .SATURATE(1), .CNT_W(16)) u_alt (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[1]), .x_in(x_in),
    .out_valid(o_vld[1]), .out_ready(out_ready), .y_out(o_y[1]), .ovf_out(o_ovf[1]),
    .ovf_sticky(o_stk[1]), .ovf_count(o_cnt[1]), .clear(clear));

  horner_poly_pipeline #(.WIDTH(W), .FRAC(F), .DEGREE(D), .ALT_SIGN(0), .SATURATE(0), .CNT_W(16)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[2]), .x_in(x_in),
    .out_valid(o_vld[2]), .out_ready(out_ready), .y_out(o_y[2]), .ovf_out(o_ovf[2]),
    .ovf_sticky(o_stk[2]), .ovf_count(o_cnt[2]), .clear(clear));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic bit cfg_alt(input int k); return k == 1; endfunction
  function automatic bit cfg_sat(input int k); return k != 2; endfunction

  function automatic longint coef_m(input int k, input bit alt);
    longint c;
    c = 65536 / (k + 1);
    if (alt && (k % 2 == 1)) c = -c;
    return c;
  endfunction

  // Evaluate the truncated series by Horner's rule in plain integers.
  function automatic longint model_y(input logic [W-1:0] x, input bit alt, input bit sat,
                                     output bit ovf);
    longint acc, xs, t;
    xs  = longint'($signed(x));
    acc = coef_m(D, alt);
    ovf = 1'b0;
    for (int k = D - 1; k >= 0; k--) begin
      t = ((acc * xs) >>> F) + coef_m(k, alt);
      if (t > 64'sd2147483647 || t < -64'sd2147483648) begin
        ovf = 1'b1;
        if (sat) t = (t < 0) ? -64'sd2147483648 : 64'sd2147483647;
        else     t = longint'($signed(t[31:0]));
      end
      acc = t;
    end
    return acc & 64'hFFFF_FFFF;
  endfunction

  // Scoreboard / protocol monitor: samples on the falling edge what the next
  // rising edge will transfer.
  initial begin
    bit             prev_rst = 1'b0;
    bit             held [3];
    logic [W-1:0]   held_y [3];
    bit             held_o [3];
    bit             stk_e [3];
    int             cnt_e [3];
    bit             eo;
    longint         ey;
    logic [W-1:0]   xv;
    for (int k = 0; k < 3; k++) begin held[k] = 0; stk_e[k] = 0; cnt_e[k] = 0; end
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("sticky%0d", k), o_stk[k], stk_e[k]);
        chk($sformatf("count%0d", k), o_cnt[k], cnt_e[k]);
        chk($sformatf("in_ready%0d", k), in_rdy[k], !o_vld[k] || out_ready);
        if (prev_rst) chk($sformatf("vld_after_rst%0d", k), o_vld[k], 0);
        if (held[k] && !prev_rst) begin
          chk($sformatf("hold_vld%0d", k), o_vld[k], 1);
          chk($sformatf("hold_y%0d", k), o_y[k], held_y[k]);
          chk($sformatf("hold_ovf%0d", k), o_ovf[k], held_o[k]);
        end
      end
      if (reset) begin
        xq.delete();
        for (int k = 0; k < 3; k++) begin held[k] = 0; stk_e[k] = 0; cnt_e[k] = 0; end
      end else begin
        if (o_vld[0] && out_ready) begin
          if (xq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL stale_output: got y=%0h with no sample in flight, want none", o_y[0]);
          end else begin
            xv = xq.pop_front();
            for (int k = 0; k < 3; k++) begin
              ey = model_y(xv, cfg_alt(k), cfg_sat(k), eo);
              chk($sformatf("vld%0d x=%0h", k, xv), o_vld[k], 1);
              chk($sformatf("y%0d x=%0h", k, xv), o_y[k], ey);
              chk($sformatf("ovf%0d x=%0h", k, xv), o_ovf[k], eo);
              if (clear) begin stk_e[k] = 0; cnt_e[k] = 0; end
              else if (eo) begin stk_e[k] = 1; if (cnt_e[k] < 65535) cnt_e[k]++; end
            end
          end
        end else if (clear) begin
          for (int k = 0; k < 3; k++) begin stk_e[k] = 0; cnt_e[k] = 0; end
        end
        for (int k = 0; k < 3; k++) begin
          held[k]   = o_vld[k] && !out_ready;
          held_y[k] = o_y[k];
          held_o[k] = o_ovf[k];
        end
        if (in_valid && in_rdy[0]) xq.push_back(x_in);
      end
      prev_rst = reset;
    end
  end

  // Single beat with literal expectations; entered and left just after a rising edge.
  task automatic one_beat(input logic [W-1:0] xv, input logic [W-1:0] ey0, input bit eo0,
                          input logic [W-1:0] ey1, input bit eo2);
    int lat;
    bit got;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x_in      = xv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    got = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_vld[0]) begin got = 1; break; end
      @(posedge clk);
      lat++;
    end
    chk($sformatf("got_output x=%0h", xv), got, 1);
    chk($sformatf("latency x=%0h", xv), lat, D);
    chk($sformatf("lit_y_sat x=%0h", xv), o_y[0], ey0);
    chk($sformatf("lit_ovf_sat x=%0h", xv), o_ovf[0], eo0);
    chk($sformatf("lit_y_alt x=%0h", xv), o_y[1], ey1);
    chk($sformatf("lit_ovf_wrap x=%0h", xv), o_ovf[2], eo2);
    @(posedge clk); #1;
  endtask

  task automatic stall_burst();
    int  i;
    int  guard;
    bit  tr;
    fork
      begin
        i = 0; guard = 0;
        in_valid = 1'b1;
        x_in = vals[0];
        while (i < 8 && guard < 100) begin
          @(negedge clk);
          tr = in_rdy[0];
          @(posedge clk); #1;
          if (tr) begin
            i++;
            if (i < 8) x_in = vals[i];
          end
          guard++;
        end
        in_valid = 1'b0;
        chk("burst_accepted", i, 8);
      end
      begin
        for (int c = 0; c < 16; c++) begin
          out_ready = !(c >= 5 && c <= 9);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (xq.size() != 0 && g < 50) begin @(posedge clk); #1; g++; end
    chk("drained", xq.size(), 0);
  endtask

  initial begin
    bit eo;
    bit got;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0; x_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", o_vld[0], 0);
    chk("rst_y", o_y[0], 0);
    chk("rst_ovf", o_ovf[0], 0);
    chk("rst_sticky", o_stk[0], 0);
    chk("rst_count", o_cnt[0], 0);
    reset = 1'b0;

    // Pin the reference model against hand-worked sums.
    chk("model_x1", model_y(32'h00010000, 0, 1, eo), 32'h00024888);
    chk("model_x1_alt", model_y(32'h00010000, 1, 1, eo), 32'h0000C888);
    chk("model_big_sat", model_y(32'h7FFF0000, 0, 1, eo), 32'h7FFFFFFF);
    chk("model_big_ovf", eo, 1);

    one_beat(32'h00000000, 32'h00010000, 0, 32'h00010000, 0);
    one_beat(32'h00010000, 32'h00024888, 0, 32'h0000C888, 0);
    one_beat(32'h7FFF0000, 32'h7FFFFFFF, 1, 32'h7FFFFFFF, 1);
    chk("lit_sticky_after_big", o_stk[0], 1);
    chk("lit_count_after_big", o_cnt[0], 1);

    stall_burst();
    drain();

    // Overflowed sample held at the output, then released together with clear.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x_in      = 32'h7FFF0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_vld[0]) begin got = 1; break; end
    end
    chk("clear_case_output", got, 1);
    chk("count_nonzero_before_clear", o_cnt[0] != 0, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    clear     = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_wins_count", o_cnt[0], 0);
    chk("clear_wins_sticky", o_stk[0], 0);

    // Reset with three samples in flight.
    one_beat(32'h7FFF0000, 32'h7FFFFFFF, 1, 32'h7FFFFFFF, 1);
    chk("count_before_reset", o_cnt[0], 1);
    in_valid = 1'b1; x_in = 32'h00010000;
    @(posedge clk); #1; x_in = 32'h7FFF0000;
    @(posedge clk); #1; x_in = 32'h00020000;
    @(posedge clk); #1; in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk("flush_out_valid", o_vld[0], 0);
    chk("flush_count", o_cnt[0], 0);
    chk("flush_sticky", o_stk[0], 0);
    repeat (10) @(posedge clk);
    #1;
    one_beat(32'h00010000, 32'h00024888, 0, 32'h0000C888, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
